// File: rtl/roic_pkg.sv
// Shared definitions for the ROIC pixel capture block: default geometry,
// capture FSM encoding and the bit layout of a buffered pixel word.
package roic_pkg;

    localparam int COLS_DEF = 320;
    localparam int ROWS_DEF = 240;
    localparam int DW_DEF   = 14;
    localparam int COL_W    = 9;
    localparam int ROW_W    = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        CAPTURE  = 2'd2,
        ROW_END  = 2'd3
    } cap_state_t;

    // Pixel word is {row_idx, eol, sof, data}, packed from the LSB up.
    function automatic int sof_bit(input int dw);
        return dw;
    endfunction

    function automatic int eol_bit(input int dw);
        return dw + 1;
    endfunction

    function automatic int row_lsb(input int dw);
        return dw + 2;
    endfunction

    function automatic int word_w(input int dw);
        return dw + 2 + ROW_W;
    endfunction

endpackage

// File: rtl/roic_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is always visible
// on o_rdata while o_empty is low. Push while full is accepted only with a pop.
module roic_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB on each pointer separates the full and empty cases.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/roic_pixel_capture.sv
// Frames ROIC ADC samples into a row/column pixel stream with SOF/EOL markers,
// buffered through a FWFT FIFO, and flags malformed rows and overflow drops.
module roic_pixel_capture
    import roic_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int DW     = DW_DEF,
    parameter int FDEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_sync,
    input  logic             dr,
    input  logic             adc_valid,
    input  logic [DW-1:0]    adc_data,
    input  logic             pix_ready,
    output logic             pix_valid,
    output logic [DW-1:0]    pix_data,
    output logic             pix_sof,
    output logic             pix_eol,
    output logic [ROW_W-1:0] row_idx,
    output logic             line_err,
    output logic             ovf_err,
    input  logic             err_clr,
    output logic             busy
);
    localparam int WW    = word_w(DW);
    localparam int SOF_B = sof_bit(DW);
    localparam int EOL_B = eol_bit(DW);
    localparam int ROW_L = row_lsb(DW);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] COL_END  = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    cap_state_t       r_state;
    cap_state_t       w_state_n;
    logic [COL_W-1:0] r_col_cnt;
    logic [COL_W-1:0] w_col_n;
    logic [ROW_W-1:0] r_row_cnt;
    logic [ROW_W-1:0] w_row_n;
    logic             r_sof_pend;
    logic             w_sof_n;
    logic             w_wr;
    logic             w_line_set;
    logic             w_ovf_set;
    logic             r_line_err;
    logic             r_ovf_err;

    logic [WW-1:0]    w_word;
    logic [WW-1:0]    r_word_p0;
    logic             r_vld_p0;

    logic [WW-1:0]    w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    always_comb begin
        w_state_n  = r_state;
        w_col_n    = r_col_cnt;
        w_row_n    = r_row_cnt;
        w_sof_n    = r_sof_pend;
        w_wr       = 1'b0;
        w_line_set = 1'b0;
        if (f_sync) begin
            // Restart framing from any state; queued pixels are left alone.
            w_state_n  = WAIT_ROW;
            w_row_n    = '0;
            w_col_n    = '0;
            w_sof_n    = 1'b1;
            w_line_set = (r_state == CAPTURE);
        end else begin
            case (r_state)
                IDLE: w_state_n = IDLE;
                WAIT_ROW: begin
                    if (dr) begin
                        w_state_n = CAPTURE;
                        w_col_n   = '0;
                    end
                end
                CAPTURE: begin
                    if (!dr) begin
                        w_state_n  = ROW_END;
                        w_line_set = (r_col_cnt < COL_END);
                    end else if (adc_valid) begin
                        w_wr    = 1'b1;
                        w_sof_n = 1'b0;
                        w_col_n = r_col_cnt + 1'b1;
                        if (r_col_cnt == COL_LAST) w_state_n = ROW_END;
                    end
                end
                ROW_END: begin
                    if (!dr) begin
                        w_row_n   = r_row_cnt + 1'b1;
                        w_state_n = (r_row_cnt == ROW_LAST) ? IDLE : WAIT_ROW;
                    end else if (adc_valid) begin
                        w_line_set = 1'b1;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    assign w_word = {r_row_cnt, (r_col_cnt == COL_LAST),
                     (r_sof_pend && (r_col_cnt == '0)), adc_data};

    // Overflow is judged at the FIFO write, one cycle after acceptance.
    assign w_pop     = ~w_empty & pix_ready;
    assign w_ovf_set = r_vld_p0 & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_sof_pend <= 1'b0;
            r_vld_p0   <= 1'b0;
            r_line_err <= 1'b0;
            r_ovf_err  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_col_cnt  <= w_col_n;
            r_row_cnt  <= w_row_n;
            r_sof_pend <= w_sof_n;
            r_vld_p0   <= w_wr;
            r_line_err <= w_line_set | (r_line_err & ~err_clr);
            r_ovf_err  <= w_ovf_set  | (r_ovf_err  & ~err_clr);
        end
    end

    // Stage p0: accepted sample word, written into the FIFO on the next edge.
    always_ff @(posedge clk) begin
        r_word_p0 <= w_word;
    end

    roic_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (FDEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_vld_p0),
        .i_wdata (r_word_p0),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Masked so stale RAM contents never appear while the stream is idle.
    assign pix_valid = ~w_empty;
    assign pix_data  = pix_valid ? w_rdata[DW-1:0] : '0;
    assign pix_sof   = pix_valid & w_rdata[SOF_B];
    assign pix_eol   = pix_valid & w_rdata[EOL_B];
    assign row_idx   = pix_valid ? w_rdata[ROW_L +: ROW_W] : '0;
    assign line_err  = r_line_err;
    assign ovf_err   = r_ovf_err;
    assign busy      = (r_state != IDLE);

endmodule
